// File: rtl/ternary_sum_arb_pkg.sv
// +----------------------------------------------------------------------+
// | ternary_sum_arb_pkg                                                   |
// | Shared widths, operand/result types and helpers for the sum arbiter. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package ternary_sum_arb_pkg;
  localparam int OPERAND_W    = 5;
  localparam int NUM_OPERANDS = 8;
  localparam int DATA_W       = OPERAND_W * NUM_OPERANDS;

  typedef logic [NUM_OPERANDS-1:0][OPERAND_W-1:0] sum_operands_t;
  typedef logic [7:0] sum_result_t;

  function automatic int id_width(input int nreq);
    return (nreq <= 2) ? 1 : $clog2(nreq);
  endfunction
endpackage

`default_nettype wire

// File: rtl/fivebit_8way_ternary.sv
// +----------------------------------------------------------------------+
// | fivebit_8way_ternary                                                  |
// | Two-stage unsigned sum of eight 5-bit operands plus a constant, mod  |
// | 256. Data registers are intentionally not reset.                     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module fivebit_8way_ternary
  import ternary_sum_arb_pkg::*;
(
  input  logic                 clk_i,
  input  sum_operands_t        operands_i,
  input  logic [OPERAND_W-1:0] const_i,
  output sum_result_t          sum_o
);
  // Each three-input group peaks at 93, so 7 bits hold it exactly.
  logic [6:0]  r_grp0;
  logic [6:0]  r_grp1;
  logic [6:0]  r_grp2;
  sum_result_t r_sum;

  always_ff @(posedge clk_i) begin
    r_grp0 <= 7'(operands_i[0]) + 7'(operands_i[1]) + 7'(operands_i[2]);
    r_grp1 <= 7'(operands_i[3]) + 7'(operands_i[4]) + 7'(operands_i[5]);
    r_grp2 <= 7'(operands_i[6]) + 7'(operands_i[7]) + 7'(const_i);
    r_sum  <= 8'(r_grp0) + 8'(r_grp1) + 8'(r_grp2);
  end

  assign sum_o = r_sum;
endmodule

`default_nettype wire

// File: rtl/ternary_sum_arb_rr.sv
// +----------------------------------------------------------------------+
// | ternary_sum_arb_rr                                                    |
// | Round-robin search from a registered pointer; one-hot grant + index. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module ternary_sum_arb_rr #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NREQ-1:0] valid_i,
  input  logic            en_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o
);
  logic [IDW-1:0] r_ptr;
  logic           w_found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      int j;
      j = int'(r_ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!w_found && valid_i[j]) begin
        w_found = 1'b1;
        idx_o   = IDW'(j);
      end
    end
    if (en_i && w_found) grant_o[idx_o] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (|grant_o) begin
      r_ptr <= (int'(idx_o) == NREQ - 1) ? '0 : idx_o + IDW'(1);
    end
  end
endmodule

`default_nettype wire

// File: rtl/ternary_sum_arbiter.sv
// +----------------------------------------------------------------------+
// | ternary_sum_arbiter                                                   |
// | Round-robin sharing of one pipelined 8-way sum with a credit-guarded |
// | result FIFO. Optional stall counter: TERNARY_SUM_ARB_STATS_EN.       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module ternary_sum_arbiter
  import ternary_sum_arb_pkg::*;
#(
  parameter int                   NREQ         = 4,
  parameter int                   ADD_LATENCY  = 2,
  parameter int                   RES_DEPTH    = 4,
  parameter logic [OPERAND_W-1:0] ADD_CONSTANT = 5'h0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NREQ-1:0]             req_valid_i,
  input  logic [NREQ*DATA_W-1:0]      req_data_i,
  output logic [NREQ-1:0]             req_ready_o,
  output logic                        res_valid_o,
  input  logic                        res_ready_i,
  output logic [id_width(NREQ)-1:0]   res_id_o,
  output sum_result_t                 res_sum_o,
  output logic [15:0]                 stat_stall_o
);
  localparam int IDW  = id_width(NREQ);
  localparam int PTRW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int CNTW = $clog2(RES_DEPTH + ADD_LATENCY + 1) + 1;

  logic [NREQ-1:0]                 w_grant;
  logic [IDW-1:0]                  w_gidx;
  logic                            w_credit_ok;
  sum_operands_t                   w_ops;
  sum_result_t                     w_add_sum;
  logic [CNTW-1:0]                 w_inflight;
  logic [CNTW-1:0]                 w_used;
  logic                            w_push;
  logic                            w_pop;

  logic [ADD_LATENCY-1:0]          r_tag_vld;
  logic [ADD_LATENCY-1:0][IDW-1:0] r_tag_id;
  sum_result_t                     r_mem_sum [RES_DEPTH];
  logic [IDW-1:0]                  r_mem_id  [RES_DEPTH];
  logic [PTRW-1:0]                 r_wr_ptr;
  logic [PTRW-1:0]                 r_rd_ptr;
  logic [CNTW-1:0]                 r_count;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (int'(p) == RES_DEPTH - 1) ? '0 : p + PTRW'(1);
  endfunction

  // Every in-flight tag already owns a FIFO slot, so the pipe can never overflow it.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < ADD_LATENCY; i++) w_inflight = w_inflight + CNTW'(r_tag_vld[i]);
  end
  assign w_used      = w_inflight + r_count;
  assign w_credit_ok = (w_used < CNTW'(RES_DEPTH));

  ternary_sum_arb_rr #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (req_valid_i),
    .en_i    (w_credit_ok & ~rst_i),
    .grant_o (w_grant),
    .idx_o   (w_gidx)
  );
  assign req_ready_o = w_grant;

  always_comb begin
    w_ops = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) w_ops = w_ops | req_data_i[i*DATA_W +: DATA_W];
    end
  end

  fivebit_8way_ternary u_add (
    .clk_i      (clk_i),
    .operands_i (w_ops),
    .const_i    (ADD_CONSTANT),
    .sum_o      (w_add_sum)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tag_vld <= '0;
      r_tag_id  <= '0;
    end else begin
      r_tag_vld[0] <= |w_grant;
      r_tag_id[0]  <= w_gidx;
      for (int i = 1; i < ADD_LATENCY; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_id[i]  <= r_tag_id[i-1];
      end
    end
  end

  assign w_push      = r_tag_vld[ADD_LATENCY-1];
  assign res_valid_o = (r_count != '0);
  assign w_pop       = res_valid_o & res_ready_i;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_sum[r_wr_ptr] <= w_add_sum;
      r_mem_id[r_wr_ptr]  <= r_tag_id[ADD_LATENCY-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + CNTW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNTW'(1);
    end
  end

  // Storage is unreset; gating keeps the head outputs at zero while empty.
  assign res_sum_o = res_valid_o ? r_mem_sum[r_rd_ptr] : '0;
  assign res_id_o  = res_valid_o ? r_mem_id[r_rd_ptr]  : '0;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_push && !w_pop && (r_count == CNTW'(RES_DEPTH))));

`ifdef TERNARY_SUM_ARB_STATS_EN
  logic [15:0] r_stall_cnt;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if ((|req_valid_i) && !w_credit_ok && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end
  assign stat_stall_o = r_stall_cnt;
`else
  assign stat_stall_o = '0;
`endif
endmodule

`default_nettype wire

// File: tb/tb_ternary_sum_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_ternary_sum_arbiter                                                |
// | Scoreboard bench: arbitration model, queued expected results.        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_ternary_sum_arbiter;
  import ternary_sum_arb_pkg::*;

  localparam int         NREQ  = 4;
  localparam int         DEPTH = 4;
  localparam logic [4:0] ADD_C = 5'd31;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NREQ-1:0]        valid = '0;
  logic [NREQ*DATA_W-1:0] data = '0;
  logic [NREQ-1:0]        ready;
  logic                   res_valid;
  logic                   res_ready = 1'b1;
  logic [1:0]             res_id;
  logic [7:0]             res_sum;
  logic [15:0]            stat;

  always #5 clk = ~clk;

  ternary_sum_arbiter #(
    .NREQ(NREQ), .ADD_LATENCY(2), .RES_DEPTH(DEPTH), .ADD_CONSTANT(ADD_C)
  ) u_dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (valid),
    .req_data_i   (data),
    .req_ready_o  (ready),
    .res_valid_o  (res_valid),
    .res_ready_i  (res_ready),
    .res_id_o     (res_id),
    .res_sum_o    (res_sum),
    .stat_stall_o (stat)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] exp_sum(input logic [DATA_W-1:0] d);
    int s;
    s = int'(ADD_C);
    for (int k = 0; k < NUM_OPERANDS; k++) s += int'(d[k*OPERAND_W +: OPERAND_W]);
    return 8'(s % 256);
  endfunction

  // Reference state: pointer, results granted but not yet popped, stall count.
  int              m_ptr = 0;
  int              m_out = 0;
  int              m_stall = 0;
  logic [9:0]      sb[$];
  logic [NREQ-1:0] last_grant = '0;
  int              fill = 1;

  always @(negedge clk) begin
    logic [NREQ-1:0] er;
    logic [9:0]      e;
    int              g;
    int              mo;
    if (rst) begin
      m_ptr = 0; m_out = 0; m_stall = 0; sb.delete(); last_grant = '0;
    end else begin
      mo = m_out;
      er = '0;
      g  = -1;
      if (mo < DEPTH) begin
        for (int i = 0; i < NREQ; i++) begin
          int j;
          j = (m_ptr + i) % NREQ;
          if (g < 0 && valid[j]) g = j;
        end
      end
      if (g >= 0) er[g] = 1'b1;
      check("ready", ready, er);
`ifdef TERNARY_SUM_ARB_STATS_EN
      check("stall_cnt", stat, m_stall);
      if ((|valid) && mo == DEPTH && m_stall < 16'hFFFF) m_stall++;
`else
      check("stall_cnt", stat, 0);
`endif
      if (sb.size() == 0) begin
        check("idle_valid", res_valid, 0);
      end else if (res_valid && res_ready) begin
        e = sb.pop_front();
        check("res_id", res_id, e[9:8]);
        check("res_sum", res_sum, e[7:0]);
        m_out--;
      end
      if (g >= 0) begin
        sb.push_back({2'(g), exp_sum(data[g*DATA_W +: DATA_W])});
        m_ptr = (g + 1) % NREQ;
        m_out++;
      end
      last_grant = er;
    end
  end

  // Granted requesters present fresh operands on the next cycle.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (last_grant[i]) begin
        for (int k = 0; k < NUM_OPERANDS; k++)
          data[i*DATA_W + k*OPERAND_W +: OPERAND_W] =
            (fill < 0) ? 5'($urandom_range(0, 31)) : 5'(fill);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    valid = '0;
    res_ready = 1'b1;
    for (int c = 0; c < 50 && sb.size() != 0; c++) step();
    step();
    check("drain", sb.size(), 0);
  endtask

  initial begin
    int cnt;
    logic [NREQ-1:0] skip_exp [4];
    skip_exp[0] = 4'b1000; skip_exp[1] = 4'b0010;
    skip_exp[2] = 4'b1000; skip_exp[3] = 4'b0010;

    for (int k = 0; k < NREQ * NUM_OPERANDS; k++) data[k*OPERAND_W +: OPERAND_W] = 5'd1;
    step(); step();
    #1;
    check("rst_ready", ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_id", res_id, 0);
    check("rst_res_sum", res_sum, 0);
    check("rst_stat", stat, 0);

    // Single request: all operands 1 plus constant 31 gives 39.
    rst = 1'b0;
    valid = 4'b0001;
    #1 check("single_ready", ready, 4'b0001);
    step(); valid = '0;
    step(); #1 check("single_early", res_valid, 0);
    step(); #1;
    check("single_valid", res_valid, 1);
    check("single_id", res_id, 0);
    check("single_sum", res_sum, 8'd39);
    drain();

    // Round robin under full rate.
    fill = -1;
    valid = '1;
    repeat (12) step();
    drain();

    // Backpressure: exactly DEPTH grants, then stall until pops return credits.
    res_ready = 1'b0;
    valid = '1;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      #1 if (|ready) cnt++;
      step();
    end
    check("bp_grants", cnt, DEPTH);
    check("bp_ready_low", ready, 0);
    res_ready = 1'b1;
    repeat (6) step();
    drain();

    // Wrap-around: 8*31 + 31 = 279 -> 23.
    fill = 31;
    for (int k = 0; k < NUM_OPERANDS; k++) data[DATA_W + k*OPERAND_W +: OPERAND_W] = 5'd31;
    valid = 4'b0010;
    step(); valid = '0;
    step(); step(); #1;
    check("wrap_valid", res_valid, 1);
    check("wrap_id", res_id, 1);
    check("wrap_sum", res_sum, 8'd23);
    drain();

    // Mid-flight reset after two grants.
    fill = -1;
    valid = '1;
    step(); step();
    rst = 1'b1;
    #1;
    check("mrst_ready", ready, 0);
    check("mrst_res_valid", res_valid, 0);
    check("mrst_res_sum", res_sum, 0);
    check("mrst_stat", stat, 0);
    step(); step();
    rst = 1'b0;
    #1;
    check("mrst_first_grant", ready, 4'b0001);
    check("mrst_no_stale", res_valid, 0);
    repeat (4) step();
    drain();

    // Skip: pointer parked at 2, only requesters 1 and 3 valid.
    valid = 4'b0010;
    step();
    valid = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      #1 check("skip_order", ready, skip_exp[c]);
      step();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end
endmodule

`default_nettype wire
